hprb_sink: RTL and testbench

Probe sink: the receiving end of the probe message channel. It accepts messages from a probe source over the standard four-phase req/ack input channel and checks three things: the redundancy field, the destination and source addresses, and the 4-bit rolling sequence number in the data field. Results are reported as sticky error flags and saturating counters. It terminates a probe path in the hgen_net fabric for bring-up and link verification.

---
 rtl/hprb_sink_pkg.sv | 10 +
 rtl/hprb_sink_if.sv | 16 +
 rtl/calc_redun.sv | 24 ++
 rtl/hprb_sink_debounce.sv | 28 ++
 rtl/hprb_sink.sv | 136 +++++++++++++
 tb/tb_hprb_sink.sv | 282 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/hprb_sink_pkg.sv
// Shared sizes for the probe message channel and the probe sink.
package hprb_sink_pkg;

  localparam int NS_ADDRESS_SIZE = 8;
  localparam int NS_DATA_SIZE    = 16;
  localparam int NS_REDUN_SIZE   = 4;
  localparam int NS_ACK_CKS      = 3;
  localparam int SEQ_W           = 4;

endpackage

// File: rtl/hprb_sink_if.sv
// Four-phase req/ack probe message channel.
interface hprb_sink_if #(
  parameter int ASZ = 8,
  parameter int DSZ = 16,
  parameter int RSZ = 4
);
  logic [ASZ-1:0] src;
  logic [ASZ-1:0] dst;
  logic [DSZ-1:0] dat;
  logic [RSZ-1:0] red;
  logic           req;
  logic           ack;

  modport master (output src, dst, dat, red, req, input ack);
  modport slave  (input src, dst, dat, red, req, output ack);
endinterface

// File: rtl/calc_redun.sv
// Channel redundancy: bit i of {src,dst,dat} (LSB = bit 0) is folded into red[i mod RSZ].
module calc_redun #(
  parameter int ASZ = 8,
  parameter int DSZ = 16,
  parameter int RSZ = 4
) (
  input  logic [ASZ-1:0] src,
  input  logic [ASZ-1:0] dst,
  input  logic [DSZ-1:0] dat,
  output logic [RSZ-1:0] red
);
  localparam int W = 2 * ASZ + DSZ;

  logic [W-1:0] flat;

  assign flat = {src, dst, dat};

  always_comb begin
    red = '0;
    for (int i = 0; i < W; i++) begin
      red[i % RSZ] = red[i % RSZ] ^ flat[i];
    end
  end
endmodule

// File: rtl/hprb_sink_debounce.sv
// Single-bit debouncer: q takes the value of d once d has differed from q for CKS consecutive clocks.
module ns_debounce #(
  parameter int CKS = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  localparam int CW = (CKS > 1) ? $clog2(CKS) : 1;
  localparam logic [CW-1:0] LOAD = CW'(CKS - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= 1'b0;
      cnt <= LOAD;
    end else if (d == q) begin
      cnt <= LOAD;
    end else if (cnt == '0) begin
      q   <= d;
      cnt <= LOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: rtl/hprb_sink.sv
// Probe sink: accepts probe messages, checks redundancy/address/sequence, keeps sticky flags and counters.
//   state    | meaning
//   INIT     | one clock after reset, clears datapath state
//   IDLE     | waiting for debounced req, latches channel fields
//   CHECK    | evaluates checks on latched fields, updates flags/counters
//   ACK      | ack register rises on leaving this state
//   WAIT_REL | ack held until debounced req falls
module hprb_sink
  import hprb_sink_pkg::*;
#(
  parameter int ASZ     = NS_ADDRESS_SIZE,
  parameter int DSZ     = NS_DATA_SIZE,
  parameter int RSZ     = NS_REDUN_SIZE,
  parameter int REQ_CKS = NS_ACK_CKS,
  parameter logic [ASZ-1:0] MY_LOCAL_ADDR = '0,
  parameter logic [ASZ-1:0] PRB_SRC_ADDR  = '0
) (
  input  logic            gch_clk,
  input  logic            gch_reset,
  output logic            gch_ready,
  hprb_sink_if.slave      rcv0,
  output logic            err_red,
  output logic            err_adr,
  output logic            err_seq,
  output logic [15:0]     msg_cnt,
  output logic [7:0]      err_cnt,
  output logic [DSZ-1:0]  last_dat
);
  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_CHECK,
    ST_ACK,
    ST_WAIT_REL
  } state_t;

  state_t state, state_nxt;

  logic             req_ckd;
  logic [ASZ-1:0]   src_q, dst_q;
  logic [DSZ-1:0]   dat_q;
  logic [RSZ-1:0]   red_q, red_calc;
  logic             synced;
  logic [SEQ_W-1:0] exp_seq;
  logic             ack_q;
  logic             red_bad, adr_bad, seq_bad, any_err;

  ns_debounce #(.CKS(REQ_CKS)) u_req_deb (
    .clk   (gch_clk),
    .rst_n (gch_reset),
    .d     (rcv0.req),
    .q     (req_ckd)
  );

  calc_redun #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_redun (
    .src (src_q),
    .dst (dst_q),
    .dat (dat_q),
    .red (red_calc)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:     state_nxt = ST_IDLE;
      ST_IDLE:     if (req_ckd) state_nxt = ST_CHECK;
      ST_CHECK:    state_nxt = ST_ACK;
      ST_ACK:      state_nxt = ST_WAIT_REL;
      ST_WAIT_REL: if (!req_ckd) state_nxt = ST_IDLE;
      default:     state_nxt = ST_INIT;
    endcase
  end

  assign red_bad = (red_calc != red_q);
  assign adr_bad = (dst_q != MY_LOCAL_ADDR) || (src_q != PRB_SRC_ADDR);
  assign seq_bad = synced && (dat_q[SEQ_W-1:0] != exp_seq);
  assign any_err = red_bad || adr_bad || seq_bad;

  always_ff @(posedge gch_clk or negedge gch_reset) begin
    if (!gch_reset) begin
      state     <= ST_INIT;
      gch_ready <= 1'b0;
      ack_q     <= 1'b0;
      src_q     <= '0;
      dst_q     <= '0;
      dat_q     <= '0;
      red_q     <= '0;
      synced    <= 1'b0;
      exp_seq   <= '0;
      err_red   <= 1'b0;
      err_adr   <= 1'b0;
      err_seq   <= 1'b0;
      msg_cnt   <= '0;
      err_cnt   <= '0;
      last_dat  <= '0;
    end else begin
      state     <= state_nxt;
      gch_ready <= (state != ST_INIT);
      // ack is registered so it rises on entry to WAIT_REL and falls on leaving it
      ack_q     <= (state_nxt == ST_WAIT_REL);
      case (state)
        ST_INIT: begin
          synced   <= 1'b0;
          exp_seq  <= '0;
          err_red  <= 1'b0;
          err_adr  <= 1'b0;
          err_seq  <= 1'b0;
          msg_cnt  <= '0;
          err_cnt  <= '0;
          last_dat <= '0;
        end
        ST_IDLE: begin
          if (req_ckd) begin
            src_q <= rcv0.src;
            dst_q <= rcv0.dst;
            dat_q <= rcv0.dat;
            red_q <= rcv0.red;
          end
        end
        ST_CHECK: begin
          if (red_bad) err_red <= 1'b1;
          if (adr_bad) err_adr <= 1'b1;
          if (seq_bad) err_seq <= 1'b1;
          synced   <= 1'b1;
          exp_seq  <= dat_q[SEQ_W-1:0] + 1'b1;
          last_dat <= dat_q;
          if (msg_cnt != 16'hFFFF) msg_cnt <= msg_cnt + 16'd1;
          if (any_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign rcv0.ack = ack_q;
endmodule

// File: tb/tb_hprb_sink.sv
// Scoreboard bench for hprb_sink: stimulus queues expected status, a monitor checks it on every ack rise.
module tb_hprb_sink;
  import hprb_sink_pkg::*;

  localparam int CKS = 3;
  localparam logic [7:0] MY  = 8'h21;
  localparam logic [7:0] PRB = 8'h05;

  logic        gch_clk = 1'b0;
  logic        gch_reset = 1'b0;
  logic        gch_ready;
  logic        err_red, err_adr, err_seq;
  logic [15:0] msg_cnt;
  logic [7:0]  err_cnt;
  logic [15:0] last_dat;

  hprb_sink_if #(.ASZ(8), .DSZ(16), .RSZ(4)) rcv0 ();

  hprb_sink #(
    .ASZ(8), .DSZ(16), .RSZ(4), .REQ_CKS(CKS),
    .MY_LOCAL_ADDR(MY), .PRB_SRC_ADDR(PRB)
  ) dut (
    .gch_clk   (gch_clk),
    .gch_reset (gch_reset),
    .gch_ready (gch_ready),
    .rcv0      (rcv0),
    .err_red   (err_red),
    .err_adr   (err_adr),
    .err_seq   (err_seq),
    .msg_cnt   (msg_cnt),
    .err_cnt   (err_cnt),
    .last_dat  (last_dat)
  );

  always #5 gch_clk = ~gch_clk;

  typedef struct packed {
    logic [15:0] msg;
    logic [7:0]  err;
    logic        e_red;
    logic        e_adr;
    logic        e_seq;
    logic [15:0] last;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int total = 0;
  int passed = 0;

  logic [15:0] m_msg;
  logic [7:0]  m_err;
  logic        m_red, m_adr, m_seq, m_synced;
  logic [3:0]  m_exp;
  logic [15:0] m_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act === req_v) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, req_v);
  endtask

  // nibble fold of {src,dst,dat}
  function automatic logic [3:0] redun(input logic [7:0] s, input logic [7:0] d, input logic [15:0] x);
    logic [31:0] f;
    logic [3:0]  r;
    f = {s, d, x};
    r = 4'h0;
    for (int k = 0; k < 8; k++) r = r ^ f[4*k +: 4];
    return r;
  endfunction

  task automatic model_reset();
    m_msg = '0; m_err = '0; m_red = 0; m_adr = 0; m_seq = 0;
    m_synced = 0; m_exp = '0; m_last = '0;
    sb_q.delete();
  endtask

  task automatic model_push(input logic [7:0] s, input logic [7:0] d, input logic [15:0] x,
                            input logic [3:0] rx);
    logic rb, ab, qb;
    exp_t e;
    rb = (rx != 4'h0);
    ab = (d != MY) || (s != PRB);
    qb = m_synced && (x[3:0] != m_exp);
    m_synced = 1'b1;
    m_exp = x[3:0] + 4'd1;
    if (m_msg != 16'hFFFF) m_msg = m_msg + 16'd1;
    if ((rb || ab || qb) && (m_err != 8'hFF)) m_err = m_err + 8'd1;
    m_red = m_red | rb;
    m_adr = m_adr | ab;
    m_seq = m_seq | qb;
    m_last = x;
    e.msg = m_msg; e.err = m_err; e.e_red = m_red; e.e_adr = m_adr; e.e_seq = m_seq; e.last = m_last;
    sb_q.push_back(e);
  endtask

  logic        prev_ack = 1'b0;
  logic [15:0] prev_msg = '0;
  int          ack_rises = 0;

  always @(negedge gch_clk) begin
    if (rcv0.ack && !prev_ack) begin
      ack_rises++;
      check("sb_has_entry", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check("msg_cnt", msg_cnt, mon_e.msg);
        check("err_cnt", err_cnt, mon_e.err);
        check("err_red", err_red, mon_e.e_red);
        check("err_adr", err_adr, mon_e.e_adr);
        check("err_seq", err_seq, mon_e.e_seq);
        check("last_dat", last_dat, mon_e.last);
        check("msg_cnt_before_ack", prev_msg, mon_e.msg);
      end
    end
    prev_ack = rcv0.ack;
    prev_msg = msg_cnt;
  end

  task automatic wait_ack(input logic level, input int limit, output int n);
    n = 0;
    while ((rcv0.ack !== level) && (n < limit)) begin
      @(posedge gch_clk); #1;
      n++;
    end
  endtask

  task automatic send(input logic [7:0] s, input logic [7:0] d, input logic [15:0] x,
                      input logic [3:0] rx);
    int n;
    model_push(s, d, x, rx);
    @(posedge gch_clk); #1;
    rcv0.src = s; rcv0.dst = d; rcv0.dat = x; rcv0.red = redun(s, d, x) ^ rx;
    rcv0.req = 1'b1;
    n = 0;
    while (!rcv0.ack && (n < 20)) begin
      @(posedge gch_clk); #1;
      n++;
      // fields change once latched; the sink must ignore this
      if (n == CKS + 1) begin
        rcv0.dat = ~x;
        rcv0.red = ~rcv0.red;
      end
    end
    check("ack_latency", n, CKS + 3);
    rcv0.req = 1'b0;
    wait_ack(1'b0, 20, n);
    check("ack_release", n, CKS + 1);
  endtask

  task automatic do_reset();
    rcv0.req = 1'b0;
    @(negedge gch_clk); gch_reset = 1'b0;
    @(negedge gch_clk); @(negedge gch_clk);
    model_reset();
    gch_reset = 1'b1;
    repeat (3) @(posedge gch_clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1);
  end

  initial begin
    int n;
    int r0;
    logic [15:0] m0;
    logic [3:0] seqs[4];
    rcv0.src = '0; rcv0.dst = '0; rcv0.dat = '0; rcv0.red = '0; rcv0.req = 1'b0;
    model_reset();
    #1;
    check("rst_ack", rcv0.ack, 0);
    check("rst_ready", gch_ready, 0);
    check("rst_flags", {err_red, err_adr, err_seq}, 0);
    check("rst_msg_cnt", msg_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_last_dat", last_dat, 0);
    @(negedge gch_clk); @(negedge gch_clk);
    gch_reset = 1'b1;
    @(posedge gch_clk); #1;
    check("ready_edge1", gch_ready, 0);
    @(posedge gch_clk); #1;
    check("ready_edge2", gch_ready, 1);

    // clean stream 0..20
    for (int i = 0; i <= 20; i++) send(PRB, MY, {4'hB, 8'(i), 4'(i)}, 4'h0);
    check("clean_msg_cnt", msg_cnt, 21);
    check("clean_err_cnt", err_cnt, 0);
    check("clean_flags", {err_red, err_adr, err_seq}, 0);
    check("clean_last_seq", last_dat[3:0], 4);

    // sequence wrap
    do_reset();
    seqs = '{4'd14, 4'd15, 4'd0, 4'd1};
    for (int i = 0; i < 4; i++) send(PRB, MY, {12'h7E1, seqs[i]}, 4'h0);
    check("wrap_err_seq", err_seq, 0);
    check("wrap_msg_cnt", msg_cnt, 4);

    // corrupted redundancy
    do_reset();
    send(PRB, MY, 16'h4440, 4'h0);
    send(PRB, MY, 16'h4441, 4'h1);
    check("red_err_red", err_red, 1);
    check("red_err_cnt", err_cnt, 1);
    check("red_msg_cnt", msg_cnt, 2);
    check("red_other_flags", {err_adr, err_seq}, 0);

    // wrong address then sequence break with resync
    do_reset();
    send(PRB, MY + 8'd1, 16'h9002, 4'h0);
    check("adr_err_adr", err_adr, 1);
    check("adr_err_cnt", err_cnt, 1);
    seqs = '{4'd3, 4'd4, 4'd7, 4'd8};
    for (int i = 0; i < 4; i++) begin
      send(PRB, MY, {12'h900, seqs[i]}, 4'h0);
      if (i == 1) check("seq_before_break", err_seq, 0);
      if (i == 2) check("seq_break", err_seq, 1);
    end
    check("seq_err_cnt", err_cnt, 2);
    check("seq_msg_cnt", msg_cnt, 5);

    // short req glitch
    r0 = ack_rises;
    m0 = msg_cnt;
    @(posedge gch_clk); #1;
    rcv0.req = 1'b1;
    repeat (CKS - 1) @(posedge gch_clk);
    #1;
    rcv0.req = 1'b0;
    repeat (12) @(posedge gch_clk);
    #1;
    check("glitch_no_ack", ack_rises, r0);
    check("glitch_ack_low", rcv0.ack, 0);
    check("glitch_msg_cnt", msg_cnt, m0);

    // reset while in WAIT_REL, req held through release
    do_reset();
    model_push(PRB, MY, 16'h2229, 4'h0);
    @(posedge gch_clk); #1;
    rcv0.src = PRB; rcv0.dst = MY; rcv0.dat = 16'h2229; rcv0.red = redun(PRB, MY, 16'h2229);
    rcv0.req = 1'b1;
    wait_ack(1'b1, 20, n);
    check("hs_ack_before_reset", rcv0.ack, 1);
    @(negedge gch_clk);
    gch_reset = 1'b0;
    #1;
    check("mid_rst_ack", rcv0.ack, 0);
    check("mid_rst_ready", gch_ready, 0);
    check("mid_rst_msg_cnt", msg_cnt, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    model_reset();
    model_push(PRB, MY, 16'h2229, 4'h0);
    @(negedge gch_clk);
    gch_reset = 1'b1;
    wait_ack(1'b1, 30, n);
    check("reaccept_ack", rcv0.ack, 1);
    check("reaccept_msg_cnt", msg_cnt, 1);
    check("reaccept_err_seq", err_seq, 0);
    rcv0.req = 1'b0;
    wait_ack(1'b0, 20, n);
    check("reaccept_release", rcv0.ack, 0);

    // err_cnt saturation
    do_reset();
    for (int i = 0; i < 300; i++) send(PRB, MY, {8'h55, 4'h0, 4'(i)}, 4'h1);
    check("sat_err_cnt", err_cnt, 8'hFF);
    check("sat_msg_cnt", msg_cnt, 300);
    check("sat_err_seq", err_seq, 0);
    repeat (4) @(posedge gch_clk);
    #1;
    check("sat_hold", err_cnt, 8'hFF);
    check("sb_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
